// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: hazard stall, bubble insertion, branch flush.
// Build option ID_EX_FORWARDING_EN: MEM/WB operand forwarding; without it every RAW dependency stalls.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alusrc,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     flush,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic                     mem_regwrite,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic                     wb_regwrite,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_regwrite,
  output logic                     ex_memread,
  output logic                     ex_valid
);

  logic                     valid_reg;
  logic [REG_ADDR-1:0]      rs1_reg;
  logic [REG_ADDR-1:0]      rs2_reg;
  logic [REG_ADDR-1:0]      rd_reg;
  logic [DATA_WIDTH-1:0]    rs1_data_reg;
  logic [DATA_WIDTH-1:0]    rs2_data_reg;
  logic [DATA_WIDTH-1:0]    imm_reg;
  logic                     alusrc_reg;
  logic [OPCODE_LENGTH-1:0] operation_reg;
  logic                     regwrite_reg;
  logic                     memread_reg;

  logic hz;
  logic load_id;

  assign ex_valid    = valid_reg;
  assign ex_rd       = rd_reg;
  assign ex_regwrite = valid_reg & regwrite_reg;
  assign ex_memread  = valid_reg & memread_reg;
  assign Operation   = operation_reg;
  assign id_ready    = !hz;

  // A bubble is the all-zero state, so reset, flush, stall and idle share one path.
  assign load_id = id_valid && !flush && !hz;

  always_ff @(posedge clk) begin
    if (reset || !load_id) begin
      valid_reg     <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      imm_reg       <= '0;
      alusrc_reg    <= 1'b0;
      operation_reg <= '0;
      regwrite_reg  <= 1'b0;
      memread_reg   <= 1'b0;
    end else begin
      valid_reg     <= 1'b1;
      rs1_reg       <= id_rs1;
      rs2_reg       <= id_rs2;
      rd_reg        <= id_rd;
      rs1_data_reg  <= id_rs1_data;
      rs2_data_reg  <= id_rs2_data;
      imm_reg       <= id_imm;
      alusrc_reg    <= id_alusrc;
      operation_reg <= id_operation;
      regwrite_reg  <= id_regwrite;
      memread_reg   <= id_memread;
    end
  end

  // One block per source operand: g_opnd[0] is rs1, g_opnd[1] is rs2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [DATA_WIDTH-1:0] data;
      logic [DATA_WIDTH-1:0] fwd;
      assign data = (gi == 0) ? rs1_data_reg : rs2_data_reg;
`ifdef ID_EX_FORWARDING_EN
      logic [REG_ADDR-1:0] rs;
      assign rs = (gi == 0) ? rs1_reg : rs2_reg;
      always_comb begin
        fwd = data;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
          fwd = mem_result;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
          fwd = wb_result;
      end
`else
      logic [REG_ADDR-1:0] id_src;
      logic                raw_hit;
      assign fwd    = data;
      assign id_src = (gi == 0) ? id_rs1 : id_rs2;
      // Any in-flight writer of a nonzero source blocks issue until it retires.
      assign raw_hit = (id_src != '0) &&
                       ((ex_regwrite  && (rd_reg == id_src)) ||
                        (mem_regwrite && (mem_rd == id_src)) ||
                        (wb_regwrite  && (wb_rd  == id_src)));
`endif
    end
  endgenerate

`ifdef ID_EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; x0 never creates a dependency.
  assign hz = ex_memread && (rd_reg != '0) && id_valid &&
              ((id_rs1 == rd_reg) || (id_rs2 == rd_reg));
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_result, rs1_reg, rs2_reg};
  assign hz = id_valid && (g_opnd[0].raw_hit || g_opnd[1].raw_hit);
`endif

  assign SrcA = g_opnd[0].fwd;
  assign SrcB = alusrc_reg ? imm_reg : g_opnd[1].fwd;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the processor. It registers decoded instruction fields and produces the `SrcA`, `SrcB` and `Operation` inputs of the ALU directly downstream. It also does operand forwarding from the MEM and WB stages, detects load-use hazards, inserts bubbles and applies branch flushes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode stage presents a valid instruction
- `id_ready`  out  1  stage accepts the ID instruction this cycle (0 = stall ID/IF)
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  source/destination register indices
- `id_rs1_data`, `id_rs2_data`  in  DATA_WIDTH  register-file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_alusrc`  in  1  1 = `SrcB` takes the immediate
- `id_operation`  in  OPCODE_LENGTH  ALU operation code
- `id_regwrite`, `id_memread`  in  1  control flags
- `flush`  in  1  taken branch; kill the instruction entering EX
- `mem_rd`  in  REG_ADDR  destination of the instruction in MEM
- `mem_regwrite`  in  1  that instruction writes a register
- `mem_result`  in  DATA_WIDTH  its ALU result
- `wb_rd`  in  REG_ADDR  destination of the instruction in WB
- `wb_regwrite`  in  1  that instruction writes a register
- `wb_result`  in  DATA_WIDTH  its write-back data
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation
- `ex_rd`  out  REG_ADDR  destination of the EX instruction
- `ex_regwrite`, `ex_memread`, `ex_valid`  out  1  EX control flags

## Operation
- Registered state: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alusrc, operation, regwrite, memread.
- Load-use hazard, `hz`:
  - Condition: `ex_valid & ex_memread & ex_rd != 0 & id_valid & (id_rs1 == ex_rd | id_rs2 == ex_rd)`.
  - Effect: `id_ready = !hz`.
- Capture per edge, in priority order:
  1. `reset` loads all state to 0.
  2. `flush` or `hz` loads a bubble: valid, regwrite, memread and operation become 0, and data fields become 0.
  3. Otherwise the stage loads the ID fields, with valid = `id_valid`. When `id_valid` = 0, it loads a bubble.
- Bubbles never write registers or read memory. `ex_regwrite` and `ex_memread` are gated by valid.
- Forwarding is combinational, using the registered rs1/rs2. For each operand:
  - If `mem_regwrite & mem_rd != 0 & mem_rd == rs`, select `mem_result`.
  - Else if `wb_regwrite & wb_rd != 0 & wb_rd == rs`, select `wb_result`.
  - Else select the registered data.
  - MEM has priority over WB. Register x0 is never forwarded.
- `SrcA` = forwarded rs1.
- `SrcB` = `alusrc ? imm : forwarded rs2`.
- `Operation` = registered operation. Code 0 is ADD; a bubble therefore computes 0+0.

## Timing
- Latency: an instruction accepted at edge N drives `SrcA`/`SrcB`/`Operation` during cycle N..N+1.
- Throughput: one instruction per cycle when there is no hazard.
- Load-use costs exactly one bubble. On the next cycle the load has moved to MEM, `hz` clears, and the value is forwarded from WB one cycle later via the normal path.
- `id_ready` is combinational from current state and ID inputs. It has no path from `mem_*` or `wb_*`.
- `flush` together with `hz`: a bubble is loaded. `id_ready` still follows `hz`; the upstream flush discards the ID instruction anyway.
- Reset values: all outputs 0 (`ex_valid`=0, `Operation`=0, `SrcA`=`SrcB`=0 since rs=0 disables forwarding). `id_ready`=1.
- Reset mid-stall: the next cycle the stage is empty and `id_ready`=1.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- Defined: forwarding as described.
- Undefined:
  - The forwarding muxes are removed. `SrcA` = registered rs1_data; `SrcB` = `alusrc ? imm : rs2_data`. The `mem_*`/`wb_*` data inputs are unused.
  - The hazard term widens to any RAW dependency. `hz` asserts while `id_valid` and a nonzero ID source matches the destination of a regwrite instruction in any of:
    - EX: `ex_rd`, with valid and regwrite
    - MEM: `mem_rd` with `mem_regwrite`
    - WB: `wb_rd` with `wb_regwrite`
  - Each stalled cycle inserts a bubble. A back-to-back dependency therefore costs 3 bubbles.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> `ex_valid`=0, `SrcA`=`SrcB`=0, `Operation`=0, `id_ready`=1.
- Plain issue: rs1_data=5, imm=7, alusrc=1, op=0000, rd=3 -> the next cycle `SrcA`=5, `SrcB`=7, `Operation`=0000, `ex_rd`=3, `ex_valid`=1.
- Forward priority: registered rs1=4, mem_rd=4 with mem_result=0xAA, wb_rd=4 with wb_result=0xBB -> `SrcA`=0xAA. Set `mem_regwrite`=0 -> `SrcA`=0xBB. Set rs1=0 -> registered data, with no forwarding.
- Load-use: a load to rd=6 in EX, then an ID instruction with rs2=6 -> `id_ready`=0 for exactly 1 cycle, then one bubble (`ex_valid`=0). The instruction then issues with `SrcB`=wb_result.
- Flush: `flush`=1 with a valid regwrite instruction in ID -> the next cycle `ex_valid`=0, `ex_regwrite`=0, `Operation`=0.
- Without `ID_EX_FORWARDING_EN`: back-to-back dependency on rd=2 -> `id_ready` low for 3 cycles, then the dependent instruction issues with register-file data.
